or1200_rfe_ctrl: RTL and testbench
==================================

Name: or1200_rfe_ctrl

Overview:
Return-from-exception sequencer. It is the exit counterpart of the exception unit's entry flush. On an l.rfe reaching EX, it restores PC from EPCR and SR from ESR, then flushes the pipeline through a short FSM. It returns to idle once fetch and decode are clear. It sits beside or1200_except and feeds genpc (PC load) and sprs (SR load).

Parameters:
FLUSH_TIMEOUT, 64, max cycles spent in FLU1 waiting for a fetch response before forcing progress (range 2..127)
TO_CNT_W, 7, width of the FLU1 wait counter; must hold FLUSH_TIMEOUT

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
ex_rfe  input  1  l.rfe valid in EX stage
ex_freeze  input  1  EX stage frozen
except_start  input  1  exception entry begins this cycle; has priority over rfe
epcr  input  32  saved exception PC
esr  input  16  saved exception SR
icpu_ack_i  input  1  instruction bus ack
icpu_err_i  input  1  instruction bus error
genpc_freeze  input  1  PC generator frozen
if_stall  input  1  fetch stall
id_freeze  input  1  decode freeze
rfe_flushpipe  output  1  flush IF/ID/EX
rfe_pc_we  output  1  one-cycle PC load strobe
rfe_pc  output  32  PC to load
sr_we  output  1  one-cycle SR load strobe
sr_restore  output  16  SR value to load
rfe_busy  output  1  high whenever state != IDLE
rfe_timeout  output  1  sticky: FLU1 wait expired
state  output  3  FSM state, exported for assertions

Behaviour:
- Reset (rst sampled at posedge clk):
  - state=IDLE(0).
  - rfe_flushpipe, rfe_pc_we, sr_we, rfe_busy, rfe_timeout = 0.
  - rfe_pc=0, sr_restore=16'h8001, wait counter=0.
  - Reset mid-sequence aborts immediately; no pending strobe survives.
- All outputs are registered. There is no combinational path from any input to any output.
- State encoding: IDLE=0, FLU1=1, FLU2=2, FLU3=3. Values 4..7 are illegal and go to IDLE next cycle with all strobes 0.
- Start condition (IDLE only): ex_rfe && !ex_freeze && !except_start. On that edge:
  - rfe_pc <= {epcr[31:2],2'b00} (forced word alignment).
  - sr_restore <= esr with bit15 (FO) forced to 1.
  - Next cycle: state=FLU1, rfe_pc_we=1, sr_we=1, rfe_flushpipe=1, rfe_busy=1, counter=0.
- ex_rfe with ex_freeze=1 is ignored. The start fires on the first unfrozen cycle.
- except_start together with ex_rfe in IDLE: rfe is dropped and the exception unit owns the PC.
- rfe_pc_we and sr_we are exactly one-cycle pulses, in the first FLU1 cycle only.
- FLU1:
  - rfe_flushpipe=1.
  - If icpu_ack_i | icpu_err_i | genpc_freeze, go to FLU2.
  - Otherwise counter increments. When counter == FLUSH_TIMEOUT-1, force FLU2 and set rfe_timeout.
  - rfe_timeout stays set until rst.
- FLU2: rfe_flushpipe=1; go to FLU3 unconditionally.
- FLU3:
  - rfe_flushpipe=0.
  - Go to IDLE when !if_stall && !id_freeze; otherwise hold.
- except_start in FLU1..FLU3 aborts to IDLE next cycle with rfe_flushpipe=0. rfe_pc and sr_restore hold their values; only the strobes matter.
- ex_rfe while busy is ignored. No queuing: the flushed l.rfe cannot legally reissue until IDLE.
- rfe_busy = (state != IDLE), registered alongside state.

Test Plan:
- Basic rfe: epcr=32'h0000_2004, esr=16'h0015, ex_rfe pulse, icpu_ack_i 2 cycles later, no stalls -> rfe_pc_we and sr_we single pulses, rfe_pc=0x2004, sr_restore=0x8015; state walks 1,1,1,2,3,0; busy for 5 cycles.
- Misaligned EPCR / FO forcing: epcr=32'h0000_3007, esr=16'h0000 -> rfe_pc=0x3004, sr_restore=0x8000.
- Priority: ex_rfe and except_start in the same cycle -> no strobes, state stays 0. Then except_start while in FLU2 -> state 0 next cycle, rfe_flushpipe=0.
- Timeout: FLUSH_TIMEOUT=4, no ack/err/genpc_freeze -> FLU2 entered after 4 FLU1 cycles, rfe_timeout=1 and stays 1 across two further rfe sequences until rst.
- Freeze/stall: ex_rfe held with ex_freeze=1 for 3 cycles -> start only on the first unfrozen cycle. In FLU3, if_stall=1 for 5 cycles -> state holds 3, then goes to 0 one cycle after if_stall drops.
- Reset mid-op: assert rst in FLU1 -> next cycle all outputs at reset values, state=0, sr_restore=0x8001.

Source files
------------

// File: rtl/or1200_rfe_ctrl.sv
// or1200_rfe_ctrl: l.rfe sequencer restoring PC/SR from EPCR/ESR and flushing the pipeline.
// Every output is a flop; next values are derived from the next state.
module or1200_rfe_ctrl #(
   parameter int FLUSH_TIMEOUT = 64,
   parameter int TO_CNT_W      = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_rfe,
   input  logic        ex_freeze,
   input  logic        except_start,
   input  logic [31:0] epcr,
   input  logic [15:0] esr,
   input  logic        icpu_ack_i,
   input  logic        icpu_err_i,
   input  logic        genpc_freeze,
   input  logic        if_stall,
   input  logic        id_freeze,
   output logic        rfe_flushpipe,
   output logic        rfe_pc_we,
   output logic [31:0] rfe_pc,
   output logic        sr_we,
   output logic [15:0] sr_restore,
   output logic        rfe_busy,
   output logic        rfe_timeout,
   output logic [2:0]  state
);
   typedef enum logic [2:0] {IDLE = 3'd0, FLU1 = 3'd1, FLU2 = 3'd2, FLU3 = 3'd3} state_e;

   localparam logic [TO_CNT_W-1:0] CNT_LAST = TO_CNT_W'(FLUSH_TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [TO_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]         pc_q, pc_d;
   logic [15:0]         sr_q, sr_d;
   logic                we_q, we_d;
   logic                flush_q, flush_d;
   logic                busy_q, busy_d;
   logic                timeout_q, timeout_d;

   always_comb begin
      state_d   = IDLE;
      cnt_d     = '0;
      pc_d      = pc_q;
      sr_d      = sr_q;
      we_d      = 1'b0;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: if (ex_rfe && !ex_freeze && !except_start) begin
            state_d = FLU1;
            we_d    = 1'b1;
            pc_d    = {epcr[31:2], 2'b00};
            sr_d    = {1'b1, esr[14:0]};
         end
         FLU1: if (except_start) state_d = IDLE;
         else if (icpu_ack_i || icpu_err_i || genpc_freeze) state_d = FLU2;
         else if (cnt_q == CNT_LAST) begin
            state_d   = FLU2;
            timeout_d = 1'b1;
         end else begin
            state_d = FLU1;
            cnt_d   = cnt_q + 1'b1;
         end
         FLU2: state_d = except_start ? IDLE : FLU3;
         FLU3: state_d = (except_start || (!if_stall && !id_freeze)) ? IDLE : FLU3;
         default: state_d = IDLE;
      endcase
      flush_d = (state_d == FLU1) || (state_d == FLU2);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pc_q      <= '0;
         sr_q      <= 16'h8001;
         we_q      <= 1'b0;
         flush_q   <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pc_q      <= pc_d;
         sr_q      <= sr_d;
         we_q      <= we_d;
         flush_q   <= flush_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign rfe_flushpipe = flush_q;
   assign rfe_pc_we     = we_q;
   assign sr_we         = we_q;
   assign rfe_pc        = pc_q;
   assign sr_restore    = sr_q;
   assign rfe_busy      = busy_q;
   assign rfe_timeout   = timeout_q;
   assign state         = state_q;
endmodule

// File: tb/tb_or1200_rfe_ctrl.sv
// tb_or1200_rfe_ctrl: directed bench for the rfe sequencer with a short flush timeout.
module tb_or1200_rfe_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_rfe = 1'b0, ex_freeze = 1'b0, except_start = 1'b0;
   logic [31:0] epcr = '0;
   logic [15:0] esr = '0;
   logic        icpu_ack_i = 1'b0, icpu_err_i = 1'b0, genpc_freeze = 1'b0;
   logic        if_stall = 1'b0, id_freeze = 1'b0;
   logic        rfe_flushpipe, rfe_pc_we, sr_we, rfe_busy, rfe_timeout;
   logic [31:0] rfe_pc;
   logic [15:0] sr_restore;
   logic [2:0]  state;
   int          n_chk = 0;
   int          n_fail = 0;

   or1200_rfe_ctrl #(.FLUSH_TIMEOUT(4), .TO_CNT_W(7)) dut (
      .clk(clk), .rst(rst), .ex_rfe(ex_rfe), .ex_freeze(ex_freeze),
      .except_start(except_start), .epcr(epcr), .esr(esr),
      .icpu_ack_i(icpu_ack_i), .icpu_err_i(icpu_err_i), .genpc_freeze(genpc_freeze),
      .if_stall(if_stall), .id_freeze(id_freeze), .rfe_flushpipe(rfe_flushpipe),
      .rfe_pc_we(rfe_pc_we), .rfe_pc(rfe_pc), .sr_we(sr_we), .sr_restore(sr_restore),
      .rfe_busy(rfe_busy), .rfe_timeout(rfe_timeout), .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_flush"}, 32'(rfe_flushpipe), 32'd0);
      chk({tag, "_pcwe"}, 32'(rfe_pc_we), 32'd0);
      chk({tag, "_srwe"}, 32'(sr_we), 32'd0);
      chk({tag, "_busy"}, 32'(rfe_busy), 32'd0);
      chk({tag, "_to"}, 32'(rfe_timeout), 32'd0);
      chk({tag, "_pc"}, rfe_pc, 32'd0);
      chk({tag, "_sr"}, 32'(sr_restore), 32'h8001);
   endtask

   task automatic quick_rfe(input string tag);
      ex_rfe = 1'b1;
      tick();
      ex_rfe = 1'b0;
      icpu_ack_i = 1'b1;
      chk({tag, "_s1"}, 32'(state), 32'd1);
      tick();
      icpu_ack_i = 1'b0;
      chk({tag, "_s2"}, 32'(state), 32'd2);
      tick();
      chk({tag, "_s3"}, 32'(state), 32'd3);
      tick();
      chk({tag, "_s0"}, 32'(state), 32'd0);
   endtask

   initial begin
      tick();
      tick();
      chk_reset("rst");
      rst = 1'b0;
      tick();
      chk("idle_state", 32'(state), 32'd0);

      epcr = 32'h0000_2004;
      esr = 16'h0015;
      ex_rfe = 1'b1;
      tick();
      ex_rfe = 1'b0;
      chk("b_state1", 32'(state), 32'd1);
      chk("b_pcwe", 32'(rfe_pc_we), 32'd1);
      chk("b_srwe", 32'(sr_we), 32'd1);
      chk("b_flush1", 32'(rfe_flushpipe), 32'd1);
      chk("b_busy1", 32'(rfe_busy), 32'd1);
      chk("b_pc", rfe_pc, 32'h0000_2004);
      chk("b_sr", 32'(sr_restore), 32'h8015);
      tick();
      chk("b_state1b", 32'(state), 32'd1);
      chk("b_pcwe_pulse", 32'(rfe_pc_we), 32'd0);
      chk("b_srwe_pulse", 32'(sr_we), 32'd0);
      tick();
      chk("b_state1c", 32'(state), 32'd1);
      icpu_ack_i = 1'b1;
      tick();
      icpu_ack_i = 1'b0;
      chk("b_state2", 32'(state), 32'd2);
      chk("b_flush2", 32'(rfe_flushpipe), 32'd1);
      tick();
      chk("b_state3", 32'(state), 32'd3);
      chk("b_flush3", 32'(rfe_flushpipe), 32'd0);
      chk("b_busy3", 32'(rfe_busy), 32'd1);
      tick();
      chk("b_state0", 32'(state), 32'd0);
      chk("b_busy0", 32'(rfe_busy), 32'd0);
      chk("b_to", 32'(rfe_timeout), 32'd0);

      epcr = 32'h0000_3007;
      esr = 16'h0000;
      ex_rfe = 1'b1;
      tick();
      ex_rfe = 1'b0;
      chk("m_pc", rfe_pc, 32'h0000_3004);
      chk("m_sr", 32'(sr_restore), 32'h8000);
      icpu_err_i = 1'b1;
      tick();
      icpu_err_i = 1'b0;
      chk("m_state2", 32'(state), 32'd2);
      tick();
      tick();
      chk("m_state0", 32'(state), 32'd0);

      epcr = 32'h0000_5000;
      ex_rfe = 1'b1;
      except_start = 1'b1;
      tick();
      except_start = 1'b0;
      ex_rfe = 1'b0;
      chk("p_state", 32'(state), 32'd0);
      chk("p_pcwe", 32'(rfe_pc_we), 32'd0);
      chk("p_srwe", 32'(sr_we), 32'd0);
      chk("p_pc_hold", rfe_pc, 32'h0000_3004);
      ex_rfe = 1'b1;
      tick();
      ex_rfe = 1'b0;
      chk("p_state1", 32'(state), 32'd1);
      icpu_ack_i = 1'b1;
      tick();
      icpu_ack_i = 1'b0;
      chk("p_state2", 32'(state), 32'd2);
      except_start = 1'b1;
      tick();
      except_start = 1'b0;
      chk("p_abort_state", 32'(state), 32'd0);
      chk("p_abort_flush", 32'(rfe_flushpipe), 32'd0);
      chk("p_abort_busy", 32'(rfe_busy), 32'd0);
      chk("p_abort_pc", rfe_pc, 32'h0000_5000);

      ex_rfe = 1'b1;
      ex_freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("f_frozen", 32'(state), 32'd0);
         chk("f_frozen_we", 32'(rfe_pc_we), 32'd0);
      end
      ex_freeze = 1'b0;
      tick();
      ex_rfe = 1'b0;
      chk("f_start", 32'(state), 32'd1);
      chk("f_start_we", 32'(rfe_pc_we), 32'd1);
      genpc_freeze = 1'b1;
      tick();
      genpc_freeze = 1'b0;
      chk("f_state2", 32'(state), 32'd2);
      if_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("f_hold3", 32'(state), 32'd3);
      end
      if_stall = 1'b0;
      tick();
      chk("f_release", 32'(state), 32'd0);

      ex_rfe = 1'b1;
      tick();
      ex_rfe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t_flu1", 32'(state), 32'd1);
         chk("t_no_to", 32'(rfe_timeout), 32'd0);
         tick();
      end
      chk("t_state2", 32'(state), 32'd2);
      chk("t_to_set", 32'(rfe_timeout), 32'd1);
      tick();
      tick();
      chk("t_state0", 32'(state), 32'd0);
      quick_rfe("t_seq2");
      chk("t_sticky2", 32'(rfe_timeout), 32'd1);
      quick_rfe("t_seq3");
      chk("t_sticky3", 32'(rfe_timeout), 32'd1);

      ex_rfe = 1'b1;
      tick();
      ex_rfe = 1'b0;
      chk("r_state1", 32'(state), 32'd1);
      rst = 1'b1;
      tick();
      chk_reset("r_mid");
      rst = 1'b0;
      tick();
      chk("r_after", 32'(state), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
